// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO read and write pointer controllers.
// Gray/binary conversions work on 32-bit zero-extended values, so any pointer width up to 32 fits.
package fifo_pkg;

  localparam int ADDR_DEFAULT = 6;
  localparam int DEPTH        = 2 ** ADDR_DEFAULT;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_gray_if.sv
// Read-side bus of the asynchronous FIFO: request, synchronised write pointer, status and RAM address.
// The raempty signal exists only when RD_AEMPTY_EN is defined.
interface fifo_rd_gray_if
  import fifo_pkg::*;
#(
  parameter int ADDR = ADDR_DEFAULT
);

  logic            rinc;
  logic [ADDR:0]   rq2_wptr;
  logic            rund_clr;
  logic [ADDR-1:0] raddr;
  logic [ADDR:0]   rptr;
  logic            rempty;
  logic            rclken;
  logic [ADDR:0]   rlevel;
  logic            runderflow;
`ifdef RD_AEMPTY_EN
  logic            raempty;

  modport master (
    output rinc, rq2_wptr, rund_clr,
    input  raddr, rptr, rempty, rclken, rlevel, runderflow, raempty
  );

  modport slave (
    input  rinc, rq2_wptr, rund_clr,
    output raddr, rptr, rempty, rclken, rlevel, runderflow, raempty
  );
`else
  modport master (
    output rinc, rq2_wptr, rund_clr,
    input  raddr, rptr, rempty, rclken, rlevel, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr, rund_clr,
    output raddr, rptr, rempty, rclken, rlevel, runderflow
  );
`endif

endinterface

// File: rtl/gray2bin_conv.sv
// Purely combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the read and write pointer controllers.
module gray2bin_conv #(
  parameter int W = 7
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/fifo_rd_gray.sv
// Read-domain pointer/flag controller of the async FIFO: Gray read pointer, registered empty, level, sticky underflow.
// Define RD_AEMPTY_EN to add the registered almost-empty flag raempty.
module fifo_rd_gray
  import fifo_pkg::*;
#(
  parameter int ADDR      = ADDR_DEFAULT,
  parameter int AEMPTY_TH = 2
) (
  input  logic          rclk,
  input  logic          rrst_n,
  fifo_rd_gray_if.slave rd
);

  logic [ADDR:0] rbin;
  logic [ADDR:0] rbin_next;
  logic [ADDR:0] rgray_next;
  logic [ADDR:0] wbin;
  logic [ADDR:0] level_next;
  logic [ADDR:0] rptr_q;
  logic [ADDR:0] rlevel_q;
  logic          rempty_q;
  logic          runderflow_q;

  gray2bin_conv #(.W(ADDR + 1)) u_wptr_conv (
    .gray (rd.rq2_wptr),
    .bin  (wbin)
  );

  // Empty and level are judged against the pointer after this cycle's read, so the last read costs no extra cycle
  assign rd.rclken  = rd.rinc & ~rempty_q;
  assign rbin_next  = rbin + {{ADDR{1'b0}}, rd.rclken};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign level_next = wbin - rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin         <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      rlevel_q     <= '0;
      runderflow_q <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rptr_q       <= rgray_next;
      rempty_q     <= (rgray_next == rd.rq2_wptr);
      rlevel_q     <= level_next;
      runderflow_q <= (rd.rinc & rempty_q) | (runderflow_q & ~rd.rund_clr);
    end
  end

  assign rd.raddr      = rbin[ADDR-1:0];
  assign rd.rptr       = rptr_q;
  assign rd.rempty     = rempty_q;
  assign rd.rlevel     = rlevel_q;
  assign rd.runderflow = runderflow_q;

`ifdef RD_AEMPTY_EN
  logic raempty_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      raempty_q <= 1'b1;
    end else begin
      raempty_q <= (level_next <= (ADDR + 1)'(AEMPTY_TH));
    end
  end

  assign rd.raempty = raempty_q;
`endif

endmodule

// File: tb/tb_fifo_rd_gray.sv
// Self-checking bench for fifo_rd_gray (ADDR=4): count-based reference model plus directed literal checks.
// raempty checks are compiled in when RD_AEMPTY_EN is defined.
module tb_fifo_rd_gray;
  import fifo_pkg::*;

  localparam int ADDR      = 4;
  localparam int AEMPTY_TH = 2;

  logic rclk;
  logic rrst_n;

  fifo_rd_gray_if #(.ADDR(ADDR)) rd_if ();

  fifo_rd_gray #(.ADDR(ADDR), .AEMPTY_TH(AEMPTY_TH)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rd     (rd_if.slave)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks   = 0;
  int failures = 0;

  // Model state: plain counts of entries written and read, no pointer encoding
  int   m_wr     = 0;
  int   m_rd     = 0;
  int   m_level  = 0;
  logic m_empty  = 1'b1;
  logic m_und    = 1'b0;
  logic m_aempty = 1'b1;
  logic m_acc;

  assign m_acc = rd_if.rinc && !m_empty;

  function automatic logic [4:0] gray5(input int v);
    int b;
    b = v % 32;
    return 5'(b ^ (b >> 1));
  endfunction

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_rd     <= 0;
      m_level  <= 0;
      m_empty  <= 1'b1;
      m_und    <= 1'b0;
      m_aempty <= 1'b1;
    end else begin
      m_rd     <= m_rd + int'(m_acc);
      m_level  <= m_wr - m_rd - int'(m_acc);
      m_empty  <= (m_wr - m_rd - int'(m_acc)) == 0;
      m_und    <= (rd_if.rinc && m_empty) || (m_und && !rd_if.rund_clr);
      m_aempty <= (m_wr - m_rd - int'(m_acc)) <= AEMPTY_TH;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic inc, input logic clr, input int wr);
    @(negedge rclk);
    rd_if.rinc     = inc;
    rd_if.rund_clr = clr;
    m_wr           = wr;
    rd_if.rq2_wptr = gray5(wr);
  endtask

  // Every cycle, compare all outputs against the count-based model
  initial begin
    forever begin
      @(negedge rclk);
      #2;
      checkOutput("cycle_outputs",
                  int'({rd_if.rptr, rd_if.raddr, rd_if.rempty, rd_if.rlevel, rd_if.runderflow, rd_if.rclken}),
                  int'({gray5(m_rd), 4'(m_rd % 16), m_empty, 5'(m_level), m_und, m_acc}));
`ifdef RD_AEMPTY_EN
      checkOutput("cycle_raempty", int'(rd_if.raempty), int'(m_aempty));
`endif
    end
  end

  initial begin
    logic [4:0] prev_rptr;
    int         lap_toggles;

    rrst_n         = 1'b0;
    rd_if.rinc     = 1'b0;
    rd_if.rund_clr = 1'b0;
    rd_if.rq2_wptr = '0;

    // Reset held while a read is requested
    applyStimulus(1'b1, 1'b0, 0);
    #2;
    checkOutput("rst_rptr", int'(rd_if.rptr), 0);
    checkOutput("rst_raddr", int'(rd_if.raddr), 0);
    checkOutput("rst_rempty", int'(rd_if.rempty), 1);
    checkOutput("rst_rlevel", int'(rd_if.rlevel), 0);
    checkOutput("rst_runderflow", int'(rd_if.runderflow), 0);
    checkOutput("rst_rclken", int'(rd_if.rclken), 0);
`ifdef RD_AEMPTY_EN
    checkOutput("rst_raempty", int'(rd_if.raempty), 1);
`endif
    applyStimulus(1'b0, 1'b0, 0);
    rrst_n = 1'b1;

    // Single entry written then read
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1);
    #2;
    checkOutput("single_rempty", int'(rd_if.rempty), 0);
    checkOutput("single_rlevel", int'(rd_if.rlevel), 1);
    applyStimulus(1'b1, 1'b0, 1);
    #2;
    checkOutput("single_rclken", int'(rd_if.rclken), 1);
    checkOutput("single_raddr", int'(rd_if.raddr), 0);
    applyStimulus(1'b0, 1'b0, 1);
    #2;
    checkOutput("single_rptr", int'(rd_if.rptr), 5'b00001);
    checkOutput("single_rempty_after", int'(rd_if.rempty), 1);
    checkOutput("single_rlevel_after", int'(rd_if.rlevel), 0);

    // Wrap: writer stays a few entries ahead up to 40, reader holds rinc high throughout
    prev_rptr   = rd_if.rptr;
    lap_toggles = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 1'b0, (i + 4 < 40) ? i + 4 : 40);
      #2;
      checkOutput("wrap_gray_onebit", int'($countones(rd_if.rptr ^ prev_rptr) <= 1), 1);
      if (rd_if.rptr[4] != prev_rptr[4]) lap_toggles++;
      prev_rptr = rd_if.rptr;
    end
    checkOutput("wrap_lap_toggles", lap_toggles, 2);
    checkOutput("wrap_raddr", int'(rd_if.raddr), 8);
    checkOutput("wrap_rptr", int'(rd_if.rptr), 5'b01100);
    checkOutput("wrap_rempty", int'(rd_if.rempty), 1);
    checkOutput("wrap_rlevel", int'(rd_if.rlevel), 0);

    // Underflow: clear, provoke, simultaneous set/clear, clear alone
    applyStimulus(1'b0, 1'b1, 40);
    applyStimulus(1'b0, 1'b0, 40);
    #2;
    checkOutput("und_cleared", int'(rd_if.runderflow), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 40);
      #2;
      checkOutput("und_rclken", int'(rd_if.rclken), 0);
      checkOutput("und_rptr_hold", int'(rd_if.rptr), 5'b01100);
    end
    applyStimulus(1'b1, 1'b1, 40);
    #2;
    checkOutput("und_set", int'(rd_if.runderflow), 1);
    applyStimulus(1'b0, 1'b1, 40);
    #2;
    checkOutput("und_set_and_clr", int'(rd_if.runderflow), 1);
    applyStimulus(1'b0, 1'b0, 40);
    #2;
    checkOutput("und_clr_alone", int'(rd_if.runderflow), 0);

    // Level stepping 5,4,3,2 over three reads
    applyStimulus(1'b0, 1'b0, 45);
    applyStimulus(1'b0, 1'b0, 45);
    #2;
    checkOutput("lvl_5", int'(rd_if.rlevel), 5);
`ifdef RD_AEMPTY_EN
    checkOutput("lvl_5_raempty", int'(rd_if.raempty), 0);
`endif
    applyStimulus(1'b1, 1'b0, 45);
    #2;
    checkOutput("lvl_5_rclken", int'(rd_if.rclken), 1);
    applyStimulus(1'b1, 1'b0, 45);
    #2;
    checkOutput("lvl_4", int'(rd_if.rlevel), 4);
    applyStimulus(1'b1, 1'b0, 45);
    #2;
    checkOutput("lvl_3", int'(rd_if.rlevel), 3);
`ifdef RD_AEMPTY_EN
    checkOutput("lvl_3_raempty", int'(rd_if.raempty), 0);
`endif
    applyStimulus(1'b0, 1'b0, 45);
    #2;
    checkOutput("lvl_2", int'(rd_if.rlevel), 2);
`ifdef RD_AEMPTY_EN
    checkOutput("lvl_2_raempty", int'(rd_if.raempty), 1);
`endif

    // Asynchronous reset between edges with seven entries pending
    applyStimulus(1'b0, 1'b0, 50);
    applyStimulus(1'b0, 1'b0, 50);
    #2;
    checkOutput("mid_rlevel_7", int'(rd_if.rlevel), 7);
    applyStimulus(1'b1, 1'b0, 50);
    @(posedge rclk);
    #2;
    rrst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rptr", int'(rd_if.rptr), 0);
    checkOutput("mid_rst_raddr", int'(rd_if.raddr), 0);
    checkOutput("mid_rst_rempty", int'(rd_if.rempty), 1);
    checkOutput("mid_rst_rlevel", int'(rd_if.rlevel), 0);
    checkOutput("mid_rst_runderflow", int'(rd_if.runderflow), 0);
    checkOutput("mid_rst_rclken", int'(rd_if.rclken), 0);
`ifdef RD_AEMPTY_EN
    checkOutput("mid_rst_raempty", int'(rd_if.raempty), 1);
`endif
    applyStimulus(1'b0, 1'b0, 0);
    rrst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
